led_share_arbiter: RTL and testbench
====================================

# led_share_arbiter

Time-shares the single blinking status LED among up to NUM_REQ requesters. Each requester asks for the LED with a 2-bit blink-rate code. The block grants one requester at a time, round-robin, for a fixed dwell window, separated by a dark gap. It drives the LED blinker's rate-select and enable inputs, and sits directly upstream of the blinker in the board-status path.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DWELL_CYCLES, 25000: clock cycles one grant is shown (1 s at the 25 kHz LED clock); must be ≥ 1.
- GAP_CYCLES, 2500: dark cycles between grants; 0 disables the gap.
- CNT_W, 32: width of the dwell/gap counter; must hold max(DWELL_CYCLES, GAP_CYCLES).
- clock  input  1  LED-domain clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  level request per requester; held while the LED is wanted.
- rate_code  input  2*NUM_REQ  rate code of requester i in bits [2i+1:2i]; 00 = 100 Hz, 01 = 50 Hz, 10 = 10 Hz, 11 = 1 Hz.
- grant  output  NUM_REQ  one-hot current owner; all zero when no owner.
- rate_sel  output  2  rate code to the blinker (bit 1 → switch1, bit 0 → switch2).
- led_enable  output  1  blinker enable; high only while a grant is shown.
- busy  output  1  high in SHOW or GAP.

## Operation
- States: IDLE, SHOW, GAP.
- **IDLE**
  - grant = 0, led_enable = 0.
  - If any req bit is set, choose a winner by round-robin: search starts at the index after last_owner and wraps modulo NUM_REQ.
  - Latch the winner's index and its rate_code into rate_sel, clear the counter, and go to SHOW.
- **SHOW**
  - grant = one-hot winner, led_enable = 1.
  - The counter increments every cycle.
  - Exit when counter == DWELL_CYCLES-1 (expiry) or when req[winner] drops (early release), whichever comes first.
  - On exit: last_owner ← winner, counter cleared. Go to GAP if GAP_CYCLES > 0, otherwise go to IDLE.
- **GAP**
  - grant = 0, led_enable = 0.
  - Count to GAP_CYCLES-1, then go to IDLE.
  - Requests are sampled only in IDLE.
- rate_sel is frozen for the whole SHOW. Changes to the winner's rate_code during SHOW are ignored.
- rate_sel holds its last value in GAP and IDLE. This is harmless because led_enable is low there.
- Other requesters' req changes during SHOW have no effect.
- busy = (state != IDLE).

## Timing
- Reset values (asynchronous, immediate on reset_n low):
  - state = IDLE, grant = 0, rate_sel = 2'b00, led_enable = 0, busy = 0.
  - counter = 0.
  - last_owner = NUM_REQ-1, so req[0] has first priority.
- Arbitration latency:
  - req seen in IDLE on cycle N gives grant, led_enable and rate_sel valid from cycle N+1.
  - A request already set on the IDLE cycle after a GAP is granted with no extra delay.
- Full dwell: grant is high for exactly DWELL_CYCLES cycles. Early release drops grant the cycle after req falls.
- Gap: exactly GAP_CYCLES cycles with grant = 0, followed by one IDLE cycle before the next grant.
- Back-to-back grant spacing is therefore DWELL_CYCLES + GAP_CYCLES + 1 cycles.
- Simultaneous events:
  - Dwell expiry and req drop on the same cycle take the single normal exit.
  - All requesters asserting together are served in order 0, 1, 2, 3, 0, …
- A single requester held continuously is re-granted after every gap.
- reset_n asserted mid-SHOW blanks the LED and clears grant immediately. After release, arbitration restarts from req[0].
- Counter width: compare with == against the parameter minus one. No wrap is reachable when CNT_W is sized as specified.
- The downstream blinker registers its select, so the LED follows rate_sel one cycle later. This module does not compensate.

## Structure
- Shared package led_pkg:
  - rate-code constants RATE_100HZ = 2'b00, RATE_50HZ = 2'b01, RATE_10HZ = 2'b10, RATE_1HZ = 2'b11.
  - state encoding for IDLE, SHOW, GAP.
- Sub-module rr_arbiter: combinational rotating-priority pick.
  - Inputs: req, last_owner.
  - Outputs: any_req, winner index, winner one-hot.
  - Reusable by other shared board resources.
- Top level holds the FSM, the counter, the rate_sel latch and last_owner.

## Test plan
Bench parameters: NUM_REQ=4, DWELL_CYCLES=10, GAP_CYCLES=3.
- Reset mid-SHOW: pulse reset_n low → grant = 0, led_enable = 0 and rate_sel = 00 immediately; after release, with req = 4'b1000, the next grant is 4'b1000 one cycle after IDLE.
- Single requester:
  - Stimulus: req = 4'b0010 held, rate_code[3:2] = 2'b10.
  - Response: grant = 4'b0010 and rate_sel = 10 the cycle after req rises.
  - led_enable is high for exactly 10 cycles, then low for 3 + 1 cycles, then the grant repeats.
- Fairness: req = 4'b1111 held → grant sequence 0001, 0010, 0100, 1000, 0001, with each window 10 cycles long and 14-cycle spacing.
- Early release:
  - Stimulus: req[0] drops on cycle 4 of SHOW.
  - Response: grant = 0 on the next cycle, GAP lasts 3 cycles, and req[1] (already pending) is granted next.
- Rate freeze: change rate_code of the owner mid-SHOW → rate_sel stays unchanged until the next grant.
- Requests during GAP:
  - Stimulus: req[2] rises during GAP.
  - Response: no grant until IDLE, then grant = 4'b0100 on the following cycle; busy is high throughout SHOW and GAP.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the board status-LED path: blinker rate codes and
// the LED share arbiter state encoding.
package led_pkg;

  // Blink-rate codes understood by the downstream LED blinker.
  localparam logic [1:0] RATE_100HZ = 2'b00;
  localparam logic [1:0] RATE_50HZ  = 2'b01;
  localparam logic [1:0] RATE_10HZ  = 2'b10;
  localparam logic [1:0] RATE_1HZ   = 2'b11;

  // Arbiter FSM: waiting for a request, showing one owner, dark gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } led_state_e;

endpackage : led_pkg

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick. The search starts at the index after
// last_owner and wraps, so the most recent owner has lowest priority.
// Kept generic so other shared board resources can reuse it.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               any_req,
  output logic [IDX_W-1:0]   win_idx,
  output logic [NUM_REQ-1:0] win_onehot
);

  // First requester found walking upward from last_owner+1 wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    any_req  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_owner) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_req && req[cand_idx]) begin
        any_req = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign win_onehot = any_req ? (NUM_REQ'(1) << win_idx) : '0;

endmodule : rr_arbiter

// File: rtl/led_share_arbiter.sv
// Time-shares the single status LED among NUM_REQ requesters: one owner at a
// time, round-robin, for DWELL_CYCLES, separated by GAP_CYCLES dark cycles.
// Drives the blinker rate-select and enable; all outputs come from flops.
module led_share_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 25000,
  parameter int GAP_CYCLES   = 2500,
  parameter int CNT_W        = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   rate_code,
  output logic [NUM_REQ-1:0]     grant,
  output logic [1:0]             rate_sel,
  output logic                   led_enable,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  // With no gap the GAP state is never entered, so its terminal count is moot.
  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  led_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [1:0]          rate_q, rate_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                en_q, en_d;

  logic                any_req;
  logic [IDX_W-1:0]    arb_idx;
  logic [NUM_REQ-1:0]  arb_onehot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_owner (last_q),
    .any_req    (any_req),
    .win_idx    (arb_idx),
    .win_onehot (arb_onehot)
  );

  // Next-state: arbitrate only in IDLE, count the dwell/gap windows, and
  // release early when the owner drops its request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    rate_d  = rate_q;
    grant_d = grant_q;
    en_d    = en_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_SHOW;
          win_d   = arb_idx;
          rate_d  = rate_code[{arb_idx, 1'b0} +: 2];
          cnt_d   = '0;
          grant_d = arb_onehot;
          en_d    = 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST || !req[win_q]) begin
          last_d  = win_q;
          cnt_d   = '0;
          grant_d = '0;
          en_d    = 1'b0;
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        grant_d = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset blanks the LED immediately and makes
  // requester 0 the first in line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      last_q  <= LAST_RST;
      rate_q  <= RATE_100HZ;
      grant_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      rate_q  <= rate_d;
      grant_q <= grant_d;
      en_q    <= en_d;
    end
  end

  assign grant      = grant_q;
  assign rate_sel   = rate_q;
  assign led_enable = en_q;
  assign busy       = (state_q != ST_IDLE);

endmodule : led_share_arbiter

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: directed scenarios plus a randomized run, all
// compared against a countdown-based reference model of the sharing rules.
module tb_led_share_arbiter;
  import led_pkg::*;

  localparam int N = 4;
  localparam int D = 10;
  localparam int G = 3;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] rate_code = '0;
  logic [N-1:0]   grant;
  logic [1:0]     rate_sel;
  logic           led_enable;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;

  led_share_arbiter #(
    .NUM_REQ(N), .DWELL_CYCLES(D), .GAP_CYCLES(G), .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .rate_code(rate_code),
    .grant(grant), .rate_sel(rate_sel), .led_enable(led_enable), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: owner index (-1 = none), show cycles left, gap cycles left.
  int         m_owner = -1;
  int         m_left = 0;
  int         m_gap = 0;
  int         m_last = N - 1;
  logic [1:0] m_rate = 2'b00;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [1:0] rate_of(input logic [2*N-1:0] rc, input int p);
    logic [2*N-1:0] sh;
    sh = rc >> (2 * p);
    return sh[1:0];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1;
      m_left  <= 0;
      m_gap   <= 0;
      m_last  <= N - 1;
      m_rate  <= 2'b00;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_left == 1) begin
        m_last  <= m_owner;
        m_owner <= -1;
        m_gap   <= G;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (m_gap > 0) begin
      m_gap <= m_gap - 1;
    end else if (req != '0) begin
      m_owner <= pick(req, m_last);
      m_left  <= D;
      m_rate  <= rate_of(rate_code, pick(req, m_last));
    end
  end

  logic [N-1:0] exp_grant;
  logic         exp_en, exp_busy;
  always_comb begin
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    exp_en   = (m_owner >= 0);
    exp_busy = (m_owner >= 0) || (m_gap > 0);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    rate_code = '0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({grant, led_enable, rate_sel, busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got g=%b e=%b r=%b b=%b want all zero", grant, led_enable, rate_sel, busy);
    end
    #5 reset_n = 1'b1;
    tick();
    // Reset mid-SHOW
    req = 4'b0001;
    rate_code = 8'h03;
    tick();
    vectors++;
    if (grant !== 4'b0001 || rate_sel !== RATE_1HZ) begin
      miscompares++;
      $display("FAIL reset_pre_grant: got g=%b r=%b want g=0001 r=11", grant, rate_sel);
    end
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({grant, led_enable, rate_sel, busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_show: got g=%b e=%b r=%b b=%b want all zero", grant, led_enable, rate_sel, busy);
    end
    #1;
    reset_n = 1'b1;
    req = 4'b1000;
    tick();
    vectors++;
    if (grant !== 4'b1000 || led_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_regrant: got g=%b e=%b want g=1000 e=1", grant, led_enable);
    end
  endtask

  task automatic test_single();
    int n, m;
    do_reset();
    req = 4'b0010;
    rate_code = 8'b0000_1000;
    tick();
    vectors++;
    if (grant !== 4'b0010 || rate_sel !== RATE_10HZ) begin
      miscompares++;
      $display("FAIL single_grant: got g=%b r=%b want g=0010 r=10", grant, rate_sel);
    end
    n = 1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!led_enable) break;
      n++;
    end
    vectors++;
    if (n !== D) begin
      miscompares++;
      $display("FAIL single_dwell: got %0d enable cycles want %0d", n, D);
    end
    m = 1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (led_enable) break;
      m++;
    end
    vectors++;
    if (m !== G + 1 || grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_gap: got %0d dark cycles g=%b want %0d g=0010", m, grant, G + 1);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] seen [5];
    int           at [5];
    int           cnt;
    logic [N-1:0] prev;
    logic [N-1:0] want;
    do_reset();
    req = 4'b1111;
    cnt = 0;
    prev = '0;
    for (int c = 0; c < 120 && cnt < 5; c++) begin
      tick();
      if (grant != '0 && prev == '0) begin
        seen[cnt] = grant;
        at[cnt] = c;
        cnt++;
      end
      prev = grant;
    end
    vectors++;
    if (cnt !== 5) begin
      miscompares++;
      $display("FAIL fair_count: got %0d grants want 5", cnt);
    end
    for (int i = 0; i < cnt; i++) begin
      want = 4'b0001 << (i % N);
      vectors++;
      if (seen[i] !== want) begin
        miscompares++;
        $display("FAIL fair_order[%0d]: got %b want %b", i, seen[i], want);
      end
      if (i > 0) begin
        vectors++;
        if (at[i] - at[i-1] !== D + G + 1) begin
          miscompares++;
          $display("FAIL fair_spacing[%0d]: got %0d want %0d", i, at[i] - at[i-1], D + G + 1);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0011;
    tick();
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL early_first: got %b want 0001", grant);
    end
    tick(); tick(); tick();
    req = 4'b0010;
    for (int k = 0; k < G; k++) begin
      tick();
      vectors++;
      if (grant !== 4'b0000 || led_enable !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL early_gap[%0d]: got g=%b e=%b b=%b want g=0000 e=0 b=1", k, grant, led_enable, busy);
      end
    end
    tick();
    vectors++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL early_idle: got g=%b b=%b want g=0000 b=0", grant, busy);
    end
    tick();
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL early_next: got %b want 0010", grant);
    end
  endtask

  task automatic test_rate_freeze();
    int k;
    do_reset();
    req = 4'b0001;
    rate_code = {6'b0, RATE_50HZ};
    tick();
    rate_code = {6'b0, RATE_1HZ};
    for (int i = 0; i < D - 1; i++) begin
      tick();
      vectors++;
      if (rate_sel !== RATE_50HZ || led_enable !== 1'b1) begin
        miscompares++;
        $display("FAIL freeze[%0d]: got r=%b e=%b want r=01 e=1", i, rate_sel, led_enable);
      end
    end
    k = 0;
    do begin
      tick();
      k++;
    end while (!led_enable && k < 30);
    vectors++;
    if (led_enable !== 1'b1 || rate_sel !== RATE_1HZ) begin
      miscompares++;
      $display("FAIL freeze_next: got e=%b r=%b want e=1 r=11", led_enable, rate_sel);
    end
  endtask

  task automatic test_gap_requests();
    do_reset();
    req = 4'b0001;
    tick();
    vectors++;
    if (busy !== 1'b1 || grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL gapreq_show: got g=%b b=%b want g=0001 b=1", grant, busy);
    end
    req = 4'b0000;
    tick();
    req = 4'b0100;
    for (int k = 0; k < G - 1; k++) begin
      tick();
      vectors++;
      if (grant !== 4'b0000 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL gapreq_gap[%0d]: got g=%b b=%b want g=0000 b=1", k, grant, busy);
      end
    end
    tick();
    vectors++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gapreq_idle: got g=%b b=%b want g=0000 b=0", grant, busy);
    end
    tick();
    vectors++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL gapreq_grant: got g=%b b=%b want g=0100 b=1", grant, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      tick();
      vectors++;
      if ({grant, led_enable, rate_sel, busy} !== {exp_grant, exp_en, m_rate, exp_busy}) begin
        miscompares++;
        $display("FAIL rand_cyc%0d: got g=%b e=%b r=%b b=%b want g=%b e=%b r=%b b=%b",
                 c, grant, led_enable, rate_sel, busy, exp_grant, exp_en, m_rate, exp_busy);
      end
      if ($urandom_range(0, 5) == 0) req = N'($urandom);
      if ($urandom_range(0, 3) == 0) rate_code = (2*N)'($urandom);
      if ($urandom_range(0, 300) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_early_release();
    test_rate_freeze();
    test_gap_requests();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_led_share_arbiter
